// File: rtl/clk_sync_pkg.sv
// Shared types and marker-frame helpers for the clock-sync pulse transmitter.
package clk_sync_pkg;

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_SYNC = 1'b1
  } mode_t;

  localparam int          MAX_DATA_W      = 512;
  localparam logic [47:0] SYNC_DMAC_DEF   = 48'h01_1B_19_00_00_00;
  localparam logic [47:0] SYNC_SMAC_DEF   = 48'h00_0A_35_00_00_01;
  localparam logic [15:0] SYNC_ETYPE_DEF  = 16'h88B5;

  // Byte 0 of the frame lands in beat[7:0]; the 22-byte header is laid out in network order.
  function automatic logic [MAX_DATA_W-1:0] build_sync_beat(
    input logic [63:0] seq,
    input logic [47:0] dmac  = SYNC_DMAC_DEF,
    input logic [47:0] smac  = SYNC_SMAC_DEF,
    input logic [15:0] etype = SYNC_ETYPE_DEF
  );
    logic [MAX_DATA_W-1:0] beat;
    logic [175:0]          hdr;
    beat = '0;
    hdr  = {dmac, smac, etype, seq};
    for (int i = 0; i < 22; i++) begin
      beat[8*i +: 8] = hdr[175-8*i -: 8];
    end
    return beat;
  endfunction

endpackage

// File: rtl/clk_sync_pulse_tx.sv
// Master-side sync-marker inserter: queues one single-beat marker frame per accepted sync pulse
// and slips it into the CMAC TX stream at packet boundaries.
module clk_sync_pulse_tx
  import clk_sync_pkg::*;
#(
  parameter int          DATA_W     = 512,
  parameter int          PEND_W     = 2,
  parameter logic [47:0] SYNC_DMAC  = SYNC_DMAC_DEF,
  parameter logic [47:0] SYNC_SMAC  = SYNC_SMAC_DEF,
  parameter logic [15:0] SYNC_ETYPE = SYNC_ETYPE_DEF
) (
  input  logic                axis_aclk,
  input  logic                axis_areset,
  input  logic                master_mode_i,
  input  logic                sync_pulse_i,
  input  logic                s_axis_tx_tvalid,
  input  logic [DATA_W-1:0]   s_axis_tx_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tx_tkeep,
  input  logic                s_axis_tx_tlast,
  output logic                s_axis_tx_tready,
  output logic                m_axis_tx_tvalid,
  output logic [DATA_W-1:0]   m_axis_tx_tdata,
  output logic [DATA_W/8-1:0] m_axis_tx_tkeep,
  output logic                m_axis_tx_tlast,
  input  logic                m_axis_tx_tready,
  output logic                sync_sent_o,
  output logic                sync_overflow_o,
  output logic [63:0]         sync_seq_o
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  mode_t                 state;
  logic                  in_pkt;
  logic [PEND_W-1:0]     pending;
  logic [63:0]           seq;
  logic                  overflow_q;

  logic                  accept;
  logic                  marker_hs;
  logic                  user_last_hs;
  logic                  boundary;
  logic                  go;
  logic                  drop;
  logic [PEND_W-1:0]     pend_next;
  logic [MAX_DATA_W-1:0] beat_full;

  assign accept       = sync_pulse_i & master_mode_i;
  assign marker_hs    = (state == ST_SYNC) & m_axis_tx_tready;
  assign user_last_hs = (state == ST_PASS) & s_axis_tx_tvalid & m_axis_tx_tready & s_axis_tx_tlast;
  // A beat already on the bus commits us to that packet, so only a truly idle link is a boundary.
  assign boundary     = (~in_pkt & ~s_axis_tx_tvalid) | user_last_hs;
  assign go           = master_mode_i & ((pending != '0) | accept);
  assign beat_full    = build_sync_beat(seq, SYNC_DMAC, SYNC_SMAC, SYNC_ETYPE);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    m_axis_tx_tvalid = s_axis_tx_tvalid;
    m_axis_tx_tdata  = s_axis_tx_tdata;
    m_axis_tx_tkeep  = s_axis_tx_tkeep;
    m_axis_tx_tlast  = s_axis_tx_tlast;
    s_axis_tx_tready = m_axis_tx_tready;
    if (state == ST_SYNC) begin
      m_axis_tx_tvalid = 1'b1;
      m_axis_tx_tdata  = beat_full[DATA_W-1:0];
      m_axis_tx_tkeep  = '1;
      m_axis_tx_tlast  = 1'b1;
      s_axis_tx_tready = 1'b0;
    end
  end

  always_comb begin
    pend_next = pending;
    drop      = 1'b0;
    unique case ({accept, marker_hs})
      2'b10: begin
        if (pending == PEND_MAX) drop = 1'b1;
        else                     pend_next = pending + PEND_W'(1);
      end
      2'b01:   pend_next = pending - PEND_W'(1);
      default: ;
    endcase
    // Leaving master mode flushes the queue, but never cuts a marker already on the bus.
    if (!master_mode_i && ((state != ST_SYNC) || marker_hs)) pend_next = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state      <= ST_PASS;
      in_pkt     <= 1'b0;
      pending    <= '0;
      seq        <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending    <= pend_next;
      overflow_q <= drop;
      if (marker_hs) seq <= seq + 64'd1;
      unique case (state)
        ST_PASS: begin
          if (user_last_hs)          in_pkt <= 1'b0;
          else if (s_axis_tx_tvalid) in_pkt <= 1'b1;
          if (go && boundary) state <= ST_SYNC;
        end
        ST_SYNC: begin
          if (marker_hs) state <= (pend_next != '0) ? ST_SYNC : ST_PASS;
        end
        default: state <= ST_PASS;
      endcase
    end
  end

  assign sync_sent_o     = marker_hs;
  assign sync_overflow_o = overflow_q;
  assign sync_seq_o      = seq;

endmodule

// File: tb/tb_clk_sync_pulse_tx.sv
// Self-checking bench for clk_sync_pulse_tx: directed scenarios plus randomized traffic
// scored against a transaction-level model of the output stream.
`timescale 1ns/1ps
module tb_clk_sync_pulse_tx;

  localparam int          DW    = 512;
  localparam int          KW    = DW/8;
  localparam logic [47:0] DMAC  = 48'h01_1B_19_00_00_00;
  localparam logic [47:0] SMAC  = 48'h00_0A_35_00_00_01;
  localparam logic [15:0] ETYPE = 16'h88B5;

  logic          axis_aclk = 1'b0;
  logic          axis_areset;
  logic          master_mode_i;
  logic          sync_pulse_i;
  logic          s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          m_tvalid, m_tlast, m_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          sync_sent, sync_ovf;
  logic [63:0]   sync_seq;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;
  beat_t user_q[$];

  always #5 axis_aclk = ~axis_aclk;

  clk_sync_pulse_tx dut (
    .axis_aclk        (axis_aclk),
    .axis_areset      (axis_areset),
    .master_mode_i    (master_mode_i),
    .sync_pulse_i     (sync_pulse_i),
    .s_axis_tx_tvalid (s_tvalid),
    .s_axis_tx_tdata  (s_tdata),
    .s_axis_tx_tkeep  (s_tkeep),
    .s_axis_tx_tlast  (s_tlast),
    .s_axis_tx_tready (s_tready),
    .m_axis_tx_tvalid (m_tvalid),
    .m_axis_tx_tdata  (m_tdata),
    .m_axis_tx_tkeep  (m_tkeep),
    .m_axis_tx_tlast  (m_tlast),
    .m_axis_tx_tready (m_tready),
    .sync_sent_o      (sync_sent),
    .sync_overflow_o  (sync_ovf),
    .sync_seq_o       (sync_seq)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  // Expected marker frame assembled byte by byte from the frame layout.
  function automatic logic [DW-1:0] marker_beat(input logic [63:0] s);
    logic [DW-1:0] r;
    logic [7:0]    b [22];
    for (int i = 0; i < 6; i++) begin
      b[i]     = 8'(DMAC >> (8*(5-i)));
      b[6+i]   = 8'(SMAC >> (8*(5-i)));
    end
    b[12] = ETYPE[15:8];
    b[13] = ETYPE[7:0];
    for (int i = 0; i < 8; i++) b[14+i] = 8'(s >> (8*(7-i)));
    r = '0;
    for (int i = 0; i < 22; i++) r[8*i +: 8] = b[i];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge axis_aclk);
    #1;
  endtask

  task automatic do_reset();
    axis_areset   = 1'b1;
    master_mode_i = 1'b1;
    sync_pulse_i  = 1'b0;
    s_tvalid      = 1'b0;
    s_tdata       = '0;
    s_tkeep       = '1;
    s_tlast       = 1'b0;
    m_tready      = 1'b1;
    repeat (3) @(posedge axis_aclk);
    #1 axis_areset = 1'b0;
  endtask

  logic [DW-1:0] d [4];
  logic [DW-1:0] e;
  int            ovf_count, valid_count;

  // Random-phase model state
  logic [63:0]   exp_seq;
  int            outstanding;
  logic          exp_ovf, m_in_pkt, prev_stall, last_s_hs, stopping, mk_hs;
  logic [DW-1:0] prev_data;
  int            pkt_left;

  initial begin
    do_reset();

    // Reset state and single-pulse latency on an idle link.
    @(negedge axis_aclk);
    check("rst_m_tvalid", 512'(m_tvalid), 512'(0));
    check("rst_s_tready", 512'(s_tready), 512'(1));
    check("rst_seq", 512'(sync_seq), 512'(0));
    check("rst_sent", 512'(sync_sent), 512'(0));
    check("rst_ovf", 512'(sync_ovf), 512'(0));
    next_cycle();
    sync_pulse_i = 1'b1;
    @(negedge axis_aclk);
    check("t1_pulse_cycle_idle", 512'(m_tvalid), 512'(0));
    next_cycle();
    sync_pulse_i = 1'b0;
    @(negedge axis_aclk);
    check("t1_marker_valid", 512'(m_tvalid), 512'(1));
    check("t1_marker_data", m_tdata, marker_beat(64'd0));
    check("t1_marker_last", 512'(m_tlast), 512'(1));
    check("t1_marker_keep", 512'(m_tkeep), 512'({KW{1'b1}}));
    check("t1_sent", 512'(sync_sent), 512'(1));
    check("t1_s_tready", 512'(s_tready), 512'(0));
    next_cycle();
    @(negedge axis_aclk);
    check("t1_seq_after", 512'(sync_seq), 512'(1));
    check("t1_back_to_pass", 512'(m_tvalid), 512'(0));
    next_cycle();

    // Pulse during beat 2 of a 4-beat packet: marker waits for the tlast.
    for (int k = 0; k < 4; k++) d[k] = rand_word();
    for (int k = 0; k < 4; k++) begin
      s_tvalid     = 1'b1;
      s_tdata      = d[k];
      s_tlast      = (k == 3);
      sync_pulse_i = (k == 1);
      @(negedge axis_aclk);
      check($sformatf("t2_beat%0d_data", k), m_tdata, d[k]);
      check($sformatf("t2_beat%0d_ready", k), 512'(s_tready), 512'(1));
      next_cycle();
    end
    sync_pulse_i = 1'b0;
    e       = rand_word();
    s_tdata = e;
    s_tlast = 1'b1;
    @(negedge axis_aclk);
    check("t2_marker_data", m_tdata, marker_beat(64'd1));
    check("t2_marker_blocks_user", 512'(s_tready), 512'(0));
    next_cycle();
    @(negedge axis_aclk);
    check("t2_user_resumes", m_tdata, e);
    next_cycle();
    s_tvalid = 1'b0;

    // Stalled sink with a user beat presented: the beat stays, marker follows the tlast.
    m_tready     = 1'b0;
    d[0]         = rand_word();
    d[1]         = rand_word();
    s_tvalid     = 1'b1;
    s_tdata      = d[0];
    s_tlast      = 1'b0;
    sync_pulse_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge axis_aclk);
      check($sformatf("t3_hold%0d", k), m_tdata, d[0]);
      check($sformatf("t3_hold%0d_valid", k), 512'(m_tvalid), 512'(1));
      next_cycle();
      sync_pulse_i = 1'b0;
    end
    m_tready = 1'b1;
    @(negedge axis_aclk);
    check("t3_beat0", m_tdata, d[0]);
    next_cycle();
    s_tdata = d[1];
    s_tlast = 1'b1;
    @(negedge axis_aclk);
    check("t3_beat1", m_tdata, d[1]);
    next_cycle();
    s_tvalid = 1'b0;
    @(negedge axis_aclk);
    check("t3_marker", m_tdata, marker_beat(64'd2));
    next_cycle();
    @(negedge axis_aclk);
    check("t3_seq", 512'(sync_seq), 512'(3));
    next_cycle();

    // Saturate the pending counter, then drain three back-to-back markers.
    m_tready  = 1'b0;
    ovf_count = 0;
    for (int k = 0; k < 7; k++) begin
      sync_pulse_i = (k < 4);
      @(negedge axis_aclk);
      if (sync_ovf) ovf_count++;
      next_cycle();
    end
    sync_pulse_i = 1'b0;
    check("t4_overflow_once", 512'(ovf_count), 512'(1));
    m_tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge axis_aclk);
      check($sformatf("t4_marker%0d", k), m_tdata, marker_beat(64'(3 + k)));
      check($sformatf("t4_sent%0d", k), 512'(sync_sent), 512'(1));
      next_cycle();
    end
    @(negedge axis_aclk);
    check("t4_drained", 512'(m_tvalid), 512'(0));
    next_cycle();

    // Pulse coincident with a marker handshake keeps one marker queued.
    sync_pulse_i = 1'b1;
    next_cycle();
    @(negedge axis_aclk);
    check("t5_first", m_tdata, marker_beat(64'd6));
    next_cycle();
    sync_pulse_i = 1'b0;
    @(negedge axis_aclk);
    check("t5_second", m_tdata, marker_beat(64'd7));
    check("t5_second_valid", 512'(m_tvalid), 512'(1));
    next_cycle();
    @(negedge axis_aclk);
    check("t5_done", 512'(m_tvalid), 512'(0));
    next_cycle();

    // Slave mode ignores pulses; leaving master mode mid-marker flushes the queue.
    master_mode_i = 1'b0;
    valid_count   = 0;
    for (int k = 0; k < 5; k++) begin
      sync_pulse_i = 1'b1;
      @(negedge axis_aclk);
      if (m_tvalid) valid_count++;
      next_cycle();
    end
    check("t6_no_markers", 512'(valid_count), 512'(0));
    check("t6_seq_kept", 512'(sync_seq), 512'(8));
    master_mode_i = 1'b1;
    m_tready      = 1'b0;
    next_cycle();
    next_cycle();
    sync_pulse_i  = 1'b0;
    master_mode_i = 1'b0;
    m_tready      = 1'b1;
    @(negedge axis_aclk);
    check("t6_marker_completes", m_tdata, marker_beat(64'd8));
    next_cycle();
    @(negedge axis_aclk);
    check("t6_flushed", 512'(m_tvalid), 512'(0));
    next_cycle();
    master_mode_i = 1'b1;
    repeat (2) begin
      @(negedge axis_aclk);
      check("t6_no_stale_marker", 512'(m_tvalid), 512'(0));
      next_cycle();
    end
    check("t6_seq", 512'(sync_seq), 512'(9));

    // Randomized traffic against a stream-level model.
    do_reset();
    exp_seq     = '0;
    outstanding = 0;
    exp_ovf     = 1'b0;
    m_in_pkt    = 1'b0;
    prev_stall  = 1'b0;
    prev_data   = '0;
    last_s_hs   = 1'b0;
    stopping    = 1'b0;
    pkt_left    = 0;
    user_q.delete();
    for (int cyc = 0; cyc < 3040; cyc++) begin
      stopping = (cyc >= 3000);
      if (!s_tvalid || last_s_hs) begin
        if (pkt_left == 0 && !stopping && $urandom_range(0, 2) == 0)
          pkt_left = $urandom_range(1, 4);
        if (pkt_left > 0) begin
          s_tvalid = 1'b1;
          s_tdata  = rand_word();
          s_tkeep  = {$urandom, $urandom};
          pkt_left--;
          s_tlast  = (pkt_left == 0);
        end else begin
          s_tvalid = 1'b0;
        end
      end
      m_tready     = stopping ? 1'b1 : ($urandom_range(0, 3) != 0);
      sync_pulse_i = !stopping && ($urandom_range(0, 5) == 0);

      @(negedge axis_aclk);
      check("rnd_ovf", 512'(sync_ovf), 512'(exp_ovf));
      if (prev_stall) begin
        check("rnd_hold_valid", 512'(m_tvalid), 512'(1));
        check("rnd_hold_data", m_tdata, prev_data);
      end
      last_s_hs = s_tvalid && s_tready;
      if (last_s_hs) user_q.push_back('{d: s_tdata, k: s_tkeep, l: s_tlast});
      mk_hs = 1'b0;
      if (m_tvalid && m_tready) begin
        if (user_q.size() > 0 && m_tdata == user_q[0].d) begin
          check("rnd_user_keep", 512'(m_tkeep), 512'(user_q[0].k));
          check("rnd_user_last", 512'(m_tlast), 512'(user_q[0].l));
          m_in_pkt = !user_q[0].l;
          void'(user_q.pop_front());
        end else begin
          mk_hs = 1'b1;
          check("rnd_marker_data", m_tdata, marker_beat(exp_seq));
          check("rnd_marker_at_boundary", 512'(m_in_pkt), 512'(0));
          check("rnd_marker_last", 512'(m_tlast), 512'(1));
          check("rnd_seq", 512'(sync_seq), 512'(exp_seq));
          exp_seq++;
        end
      end
      check("rnd_sent", 512'(sync_sent), 512'(mk_hs));
      if (sync_pulse_i && !mk_hs && outstanding == 3) begin
        exp_ovf = 1'b1;
      end else begin
        exp_ovf     = 1'b0;
        outstanding = outstanding + int'(sync_pulse_i) - int'(mk_hs);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      next_cycle();
    end
    check("drain_user_queue", 512'(user_q.size()), 512'(0));
    check("drain_outstanding", 512'(outstanding), 512'(0));
    check("drain_seq", 512'(sync_seq), 512'(exp_seq));
    @(negedge axis_aclk);
    check("drain_idle", 512'(m_tvalid), 512'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
